// File: rtl/interrupt_exception_seq_pkg.sv
// -----------------------------------------------------------------------------
// int_seq_pkg
// Shared types and constants for the interrupt/exception entry sequencer:
//   - seq_state_e : sequencer FSM states
//   - INTM_0/INTM_2 : interrupt control mode encodings
//   - VEC_BASE_DEF/STK_STEP_DEF : default vector-table base and push step
//   - irq_ctx_t : context captured at acceptance and used for the whole entry
// -----------------------------------------------------------------------------
package int_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_PC  = 3'd1,
        ST_PUSH_CCR = 3'd2,
        ST_FETCH    = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

    localparam logic [1:0]  INTM_0       = 2'b00;
    localparam logic [1:0]  INTM_2       = 2'b10;
    localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0000;
    localparam int unsigned STK_STEP_DEF = 4;

    // Everything the sequence needs, frozen at the acceptance edge so that
    // the CPU/controller inputs may change freely while the entry runs.
    typedef struct packed {
        logic [7:0]  vector;
        logic [2:0]  prio;
        logic [31:0] pc;
        logic [31:0] sp;
        logic [7:0]  ccr;
        logic [2:0]  exr;
        logic        mode2;
    } irq_ctx_t;

    // Only 2'b10 selects mode 2; every other encoding behaves as mode 0.
    function automatic logic is_mode2(input logic [1:0] intm);
        return intm == INTM_2;
    endfunction

    // Second stacked word: EXR rides above the CCR only in mode 2.
    function automatic logic [31:0] ccr_frame(input logic mode2,
                                              input logic [2:0] exr,
                                              input logic [7:0] ccr);
        return mode2 ? {21'b0, exr, ccr} : {24'b0, ccr};
    endfunction

endpackage

// File: rtl/interrupt_exception_seq_if.sv
// -----------------------------------------------------------------------------
// interrupt_exception_seq_if
// Memory bus used by the sequencer for the two stack pushes and the vector
// fetch. Request/address/data/we are held until mem_ack is sampled high.
//   master : sequencer side (drives req/we/addr/wdata, receives ack/rdata)
//   slave  : memory side
// -----------------------------------------------------------------------------
interface interrupt_exception_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/interrupt_exception_seq.sv
// -----------------------------------------------------------------------------
// interrupt_exception_seq
// Interrupt entry sequencer. At an instruction boundary with a pending
// interrupt it stalls the CPU, pushes PC then CCR (plus EXR in mode 2) onto
// the stack, fetches the handler address from the vector table, and emits a
// one-cycle DONE strobe carrying the new PC/SP while updating the mask state.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   interrupt_request_i             pending interrupt
//   vector_number_i, int_prio_i     vector and priority of that interrupt
//   INTM_i                          interrupt control mode
//   inst_boundary_i                 CPU at instruction boundary
//   cur_pc_i, cur_sp_i, cur_ccr_i   CPU state to be stacked
//   mask_wr_i, mask_i_in_i,
//   mask_exr_in_i                   software load of I_bit/EXR (IDLE only)
//   mem                             memory bus (master modport)
//   cpu_stall_o                     high for the whole sequence
//   new_pc_o, new_sp_o,
//   new_pc_valid_o                  handler entry values, valid in DONE
//   interrupt_exception_handling_o  DONE pulse to the interrupt controller
//   I_bit_o, EXR_o                  current interrupt mask state
// -----------------------------------------------------------------------------
module interrupt_exception_seq
    import int_seq_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEF,
    parameter int unsigned STK_STEP = STK_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        interrupt_request_i,
    input  logic [7:0]  vector_number_i,
    input  logic [2:0]  int_prio_i,
    input  logic [1:0]  INTM_i,
    input  logic        inst_boundary_i,
    input  logic [31:0] cur_pc_i,
    input  logic [31:0] cur_sp_i,
    input  logic [7:0]  cur_ccr_i,
    input  logic        mask_wr_i,
    input  logic        mask_i_in_i,
    input  logic [2:0]  mask_exr_in_i,
    interrupt_exception_seq_if.master mem,
    output logic        cpu_stall_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] new_sp_o,
    output logic        new_pc_valid_o,
    output logic        interrupt_exception_handling_o,
    output logic        I_bit_o,
    output logic [2:0]  EXR_o
);

    localparam logic [31:0] STEP1 = 32'(STK_STEP);
    localparam logic [31:0] STEP2 = 32'(2 * STK_STEP);

    seq_state_e  state_q, state_d;
    irq_ctx_t    ctx_q;
    logic [31:0] fetch_q;
    logic        i_bit_q;
    logic [2:0]  exr_q;
    logic        accept;

    logic        req_c, we_c;
    logic [31:0] addr_c, wdata_c;

    assign accept = (state_q == ST_IDLE) && interrupt_request_i && inst_boundary_i;

    // -------------------------------------------------------------------------
    // State and context registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctx_q   <= '0;
            fetch_q <= '0;
            i_bit_q <= 1'b1;
            exr_q   <= 3'b111;
        end else begin
            state_q <= state_d;

            if (accept) begin
                ctx_q.vector <= vector_number_i;
                ctx_q.prio   <= int_prio_i;
                ctx_q.pc     <= cur_pc_i;
                ctx_q.sp     <= cur_sp_i;
                ctx_q.ccr    <= cur_ccr_i;
                ctx_q.exr    <= exr_q;
                ctx_q.mode2  <= is_mode2(INTM_i);
            end

            if (state_q == ST_FETCH && mem.mem_ack) begin
                fetch_q <= mem.mem_rdata;
            end

            // The entry's own mask update takes precedence; software loads
            // are honoured only while no sequence is in flight.
            if (state_q == ST_DONE) begin
                i_bit_q <= 1'b1;
                if (ctx_q.mode2) begin
                    exr_q <= ctx_q.prio;
                end
            end else if (state_q == ST_IDLE && mask_wr_i) begin
                i_bit_q <= mask_i_in_i;
                exr_q   <= mask_exr_in_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and bus outputs. Bus fields are pure functions of state and
    // frozen context, so they stay put for as long as the memory waits.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_PUSH_PC;
            end
            ST_PUSH_PC: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = ctx_q.sp - STEP1;
                wdata_c = ctx_q.pc;
                if (mem.mem_ack) state_d = ST_PUSH_CCR;
            end
            ST_PUSH_CCR: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = ctx_q.sp - STEP2;
                wdata_c = ccr_frame(ctx_q.mode2, ctx_q.exr, ctx_q.ccr);
                if (mem.mem_ack) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                req_c  = 1'b1;
                addr_c = VEC_BASE + {22'b0, ctx_q.vector, 2'b00};
                if (mem.mem_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;

    assign cpu_stall_o                    = (state_q != ST_IDLE);
    assign new_pc_valid_o                 = (state_q == ST_DONE);
    assign interrupt_exception_handling_o = (state_q == ST_DONE);
    assign new_pc_o = (state_q == ST_DONE) ? fetch_q : '0;
    assign new_sp_o = (state_q == ST_DONE) ? (ctx_q.sp - STEP2) : '0;
    assign I_bit_o  = i_bit_q;
    assign EXR_o    = exr_q;

endmodule

// File: tb/tb_interrupt_exception_seq.sv
module tb_interrupt_exception_seq;
    import int_seq_pkg::*;

    localparam logic [31:0] VB   = 32'h0000_0000;
    localparam int unsigned STEP = 4;

    logic        clk, rst_n;
    logic        interrupt_request, inst_boundary, mask_wr, mask_i_in;
    logic [7:0]  vector_number, cur_ccr;
    logic [2:0]  int_prio, mask_exr_in;
    logic [1:0]  INTM;
    logic [31:0] cur_pc, cur_sp;
    logic        cpu_stall_o, new_pc_valid_o, interrupt_exception_handling_o, I_bit_o;
    logic [31:0] new_pc_o, new_sp_o;
    logic [2:0]  EXR_o;

    interrupt_exception_seq_if bus();

    interrupt_exception_seq #(.VEC_BASE(VB), .STK_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .interrupt_request_i(interrupt_request), .vector_number_i(vector_number),
        .int_prio_i(int_prio), .INTM_i(INTM), .inst_boundary_i(inst_boundary),
        .cur_pc_i(cur_pc), .cur_sp_i(cur_sp), .cur_ccr_i(cur_ccr),
        .mask_wr_i(mask_wr), .mask_i_in_i(mask_i_in), .mask_exr_in_i(mask_exr_in),
        .mem(bus),
        .cpu_stall_o(cpu_stall_o), .new_pc_o(new_pc_o), .new_sp_o(new_sp_o),
        .new_pc_valid_o(new_pc_valid_o),
        .interrupt_exception_handling_o(interrupt_exception_handling_o),
        .I_bit_o(I_bit_o), .EXR_o(EXR_o)
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0, n_pulse = 0, last_lat = -1;

    // Memory model controls and transfer log
    int  mem_wait = 0;
    bit  mem_rand = 0, stray_en = 0;
    int  wcnt, cur_wait;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic [31:0] q_addr[$], q_data[$];
    bit          q_we[$];
    int          q_wait[$];

    // Reference mask state
    bit         m_ibit;
    logic [2:0] m_exr;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (interrupt_exception_handling_o === 1'b1) n_pulse++;
    end

    // Memory responder: acks after cur_wait wait cycles, checks bus stability
    // while waiting, logs every completed transfer.
    initial begin
        bus.mem_ack = 0; bus.mem_rdata = 0; wcnt = 0; cur_wait = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (wcnt == 0) begin
                    h_addr = bus.mem_addr; h_wdata = bus.mem_wdata; h_we = bus.mem_we;
                    cur_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
                end else begin
                    n_cmp++;
                    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {h_we, h_addr, h_wdata}) begin
                        n_err++;
                        $display("FAIL bus_stable: we/addr/wdata=%b/%h/%h expected %b/%h/%h",
                                 bus.mem_we, bus.mem_addr, bus.mem_wdata, h_we, h_addr, h_wdata);
                    end
                end
                if (wcnt >= cur_wait) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = h_we ? $urandom : rd_word(h_addr);
                    q_addr.push_back(h_addr); q_data.push_back(h_wdata);
                    q_we.push_back(h_we); q_wait.push_back(cur_wait);
                    wcnt = 0;
                end else begin
                    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom; wcnt++;
                end
            end else begin
                bus.mem_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_rdata = $urandom;
                wcnt = 0;
            end
        end
    end

    task automatic clear_log();
        q_addr.delete(); q_data.delete(); q_we.delete(); q_wait.delete();
    endtask

    task automatic set_mask(input bit i, input logic [2:0] e);
        @(negedge clk);
        mask_wr = 1; mask_i_in = i; mask_exr_in = e;
        @(posedge clk); #1;
        mask_wr = 0;
        n_cmp++;
        if (I_bit_o !== i || EXR_o !== e) begin
            n_err++;
            $display("FAIL mask_load: I/EXR=%b/%0d expected %b/%0d", I_bit_o, EXR_o, i, e);
        end
        m_ibit = i; m_exr = e;
    endtask

    // One complete interrupt entry, checked against the reference model.
    task automatic run_irq(input logic [7:0] vec, input logic [2:0] prio,
                           input logic [31:0] pc, input logic [31:0] sp,
                           input logic [7:0] ccr, input logic [1:0] intm,
                           input int nb_low, input bit noise, input bit mask_in_done);
        logic [31:0] e_a0, e_a1, e_a2, e_d0, e_d1, e_pc, e_sp;
        logic [2:0]  e_exr;
        int acc, wsum;
        bit got;
        clear_log();
        e_a0  = sp - STEP;
        e_d0  = pc;
        e_a1  = sp - 2 * STEP;
        e_d1  = (intm == 2'b10) ? ({24'd0, ccr} + {29'd0, m_exr} * 32'd256) : {24'd0, ccr};
        e_a2  = VB + {24'd0, vec} * 32'd4;
        e_pc  = rd_word(e_a2);
        e_sp  = sp - 2 * STEP;
        e_exr = (intm == 2'b10) ? prio : m_exr;

        @(negedge clk);
        interrupt_request = 1; vector_number = vec; int_prio = prio; cur_pc = pc;
        cur_sp = sp; cur_ccr = ccr; INTM = intm; inst_boundary = (nb_low == 0);
        for (int k = 0; k < nb_low; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.mem_req !== 1'b0 || cpu_stall_o !== 1'b0) begin
                n_err++;
                $display("FAIL boundary_hold: req/stall=%b/%b expected 0/0", bus.mem_req, cpu_stall_o);
            end
        end
        inst_boundary = 1;
        @(posedge clk); #1;
        acc = cyc;
        // Scramble inputs: the sequence must run on the latched copies.
        interrupt_request = 0; vector_number = $urandom; int_prio = $urandom;
        cur_pc = $urandom; cur_sp = $urandom; cur_ccr = $urandom; INTM = $urandom;
        inst_boundary = $urandom;

        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (interrupt_exception_handling_o === 1'b1) got = 1;
            else begin
                n_cmp++;
                if (cpu_stall_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_during_seq: stall=%b expected 1", cpu_stall_o);
                end
                if (noise) begin
                    mask_wr = $urandom; mask_i_in = $urandom; mask_exr_in = $urandom;
                end
            end
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: no DONE pulse within 300 cycles");
            mask_wr = 0;
            return;
        end

        wsum = 0;
        foreach (q_wait[i]) wsum += q_wait[i];
        last_lat = cyc - acc;
        n_cmp++;
        if (last_lat != 3 + wsum) begin
            n_err++; $display("FAIL latency: got %0d expected %0d", last_lat, 3 + wsum);
        end
        n_cmp++;
        if (new_pc_valid_o !== 1'b1 || bus.mem_req !== 1'b0 || cpu_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL done_flags: valid/req/stall=%b/%b/%b expected 1/0/1",
                     new_pc_valid_o, bus.mem_req, cpu_stall_o);
        end
        n_cmp++;
        if (new_pc_o !== e_pc) begin
            n_err++; $display("FAIL new_pc: got %h expected %h", new_pc_o, e_pc);
        end
        n_cmp++;
        if (new_sp_o !== e_sp) begin
            n_err++; $display("FAIL new_sp: got %h expected %h", new_sp_o, e_sp);
        end
        n_cmp++;
        if (q_addr.size() != 3) begin
            n_err++; $display("FAIL xfer_count: got %0d expected 3", q_addr.size());
        end else begin
            n_cmp++;
            if (q_we[0] !== 1'b1 || q_addr[0] !== e_a0 || q_data[0] !== e_d0) begin
                n_err++;
                $display("FAIL push_pc: we/addr/data=%b/%h/%h expected 1/%h/%h", q_we[0], q_addr[0], q_data[0], e_a0, e_d0);
            end
            n_cmp++;
            if (q_we[1] !== 1'b1 || q_addr[1] !== e_a1 || q_data[1] !== e_d1) begin
                n_err++;
                $display("FAIL push_ccr: we/addr/data=%b/%h/%h expected 1/%h/%h", q_we[1], q_addr[1], q_data[1], e_a1, e_d1);
            end
            n_cmp++;
            if (q_we[2] !== 1'b0 || q_addr[2] !== e_a2) begin
                n_err++;
                $display("FAIL vec_fetch: we/addr=%b/%h expected 0/%h", q_we[2], q_addr[2], e_a2);
            end
        end

        if (mask_in_done) begin
            mask_wr = 1; mask_i_in = 0; mask_exr_in = 3'b010;
        end
        @(posedge clk); #1;
        mask_wr = 0;
        n_cmp++;
        if (I_bit_o !== 1'b1 || EXR_o !== e_exr) begin
            n_err++; $display("FAIL mask_after_done: I/EXR=%b/%0d expected 1/%0d", I_bit_o, EXR_o, e_exr);
        end
        n_cmp++;
        if (interrupt_exception_handling_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_idle: pulse/stall=%b/%b expected 0/0", interrupt_exception_handling_o, cpu_stall_o);
        end
        m_ibit = 1; m_exr = e_exr;
    endtask

    task automatic test_reset();
        rst_n = 0; interrupt_request = 0; inst_boundary = 0; vector_number = 0; int_prio = 0;
        INTM = 0; cur_pc = 0; cur_sp = 0; cur_ccr = 0; mask_wr = 0; mask_i_in = 0; mask_exr_in = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, cpu_stall_o, new_pc_valid_o, interrupt_exception_handling_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: req/we/stall/valid/pulse=%b%b%b%b%b expected 00000", bus.mem_req,
                     bus.mem_we, cpu_stall_o, new_pc_valid_o, interrupt_exception_handling_o);
        end
        n_cmp++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_err++; $display("FAIL reset_bus: addr/wdata=%h/%h expected 0/0", bus.mem_addr, bus.mem_wdata);
        end
        n_cmp++;
        if (new_pc_o !== 32'h0 || new_sp_o !== 32'h0) begin
            n_err++; $display("FAIL reset_newpc: pc/sp=%h/%h expected 0/0", new_pc_o, new_sp_o);
        end
        n_cmp++;
        if (I_bit_o !== 1'b1 || EXR_o !== 3'b111) begin
            n_err++; $display("FAIL reset_mask: I/EXR=%b/%0d expected 1/7", I_bit_o, EXR_o);
        end
        m_ibit = 1; m_exr = 3'b111;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_mode2();
        mem_rand = 0; mem_wait = 0; stray_en = 0;
        set_mask(0, 3'd0);
        run_irq(8'h40, 3'd5, 32'h1000, 32'h8000, 8'h0A, 2'b10, 0, 0, 0);
        n_cmp++;
        if (last_lat != 3 || EXR_o !== 3'd5 || q_data.size() < 2 || q_data[1] !== 32'h0A || q_addr[0] !== 32'h7FFC) begin
            n_err++; $display("FAIL mode2_directed: lat=%0d EXR=%0d expected 3/5", last_lat, EXR_o);
        end
    endtask

    task automatic test_mode0();
        set_mask(0, 3'd0);
        run_irq(8'h40, 3'd5, 32'h1000, 32'h8000, 8'h0A, 2'b00, 0, 0, 0);
        n_cmp++;
        if (EXR_o !== 3'd0 || q_data.size() < 2 || q_data[1] !== 32'h0000_000A) begin
            n_err++; $display("FAIL mode0_directed: EXR=%0d expected 0", EXR_o);
        end
    endtask

    task automatic test_wait_states();
        set_mask(0, 3'd1);
        mem_wait = 2;
        run_irq(8'h40, 3'd5, 32'h1000, 32'h8000, 8'h0A, 2'b10, 0, 0, 0);
        n_cmp++;
        if (last_lat != 9) begin
            n_err++; $display("FAIL wait_latency: got %0d expected 9", last_lat);
        end
        mem_wait = 0;
    endtask

    task automatic test_boundary_hold();
        run_irq(8'h07, 3'd2, 32'h0000_2000, 32'h0000_0100, 8'h55, 2'b10, 5, 0, 0);
    endtask

    task automatic test_reset_mid();
        bit found;
        int p0;
        set_mask(0, 3'b011);
        mem_wait = 1;
        @(negedge clk);
        interrupt_request = 1; inst_boundary = 1; vector_number = 8'h10; int_prio = 3'd4;
        INTM = 2'b10; cur_pc = 32'h3000; cur_sp = 32'h4000; cur_ccr = 8'h11;
        @(posedge clk); #1;
        interrupt_request = 0;
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL reach_fetch: fetch phase not seen expected within 50 cycles");
        end
        p0 = n_pulse;
        rst_n = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.mem_req !== 1'b0 || cpu_stall_o !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: req/stall=%b/%b expected 0/0", bus.mem_req, cpu_stall_o);
        end
        @(negedge clk); rst_n = 1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (n_pulse != p0) begin
            n_err++; $display("FAIL abort_pulse: got %0d pulses expected 0", n_pulse - p0);
        end
        n_cmp++;
        if (I_bit_o !== 1'b1 || EXR_o !== 3'd7) begin
            n_err++; $display("FAIL abort_mask: I/EXR=%b/%0d expected 1/7", I_bit_o, EXR_o);
        end
        m_ibit = 1; m_exr = 3'd7;
        mem_wait = 0;
    endtask

    task automatic test_mask_done();
        set_mask(0, 3'd0);
        run_irq(8'h21, 3'd6, 32'hDEAD_BEE0, 32'h0000_9000, 8'hC3, 2'b10, 0, 0, 1);
        n_cmp++;
        if (EXR_o !== 3'd6) begin
            n_err++; $display("FAIL done_wins: EXR=%0d expected 6", EXR_o);
        end
        set_mask(0, 3'b010);
    endtask

    task automatic test_back_to_back();
        int p1, p2;
        clear_log();
        @(negedge clk);
        interrupt_request = 1; inst_boundary = 1; vector_number = 8'h22; int_prio = 3'd3;
        INTM = 2'b10; cur_pc = 32'h5000; cur_sp = 32'h6000; cur_ccr = 8'h01;
        p1 = -1; p2 = -1;
        for (int k = 0; k < 40 && p2 < 0; k++) begin
            @(negedge clk);
            if (interrupt_exception_handling_o === 1'b1) begin
                if (p1 < 0) p1 = cyc; else p2 = cyc;
            end
        end
        interrupt_request = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (p1 < 0 || p2 - p1 != 5) begin
            n_err++; $display("FAIL back_to_back: pulse spacing %0d expected 5", p2 - p1);
        end
        m_ibit = 1; m_exr = 3'd3;
    endtask

    task automatic test_random();
        logic [31:0] sp;
        mem_rand = 1; stray_en = 1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) set_mask(1'($urandom), 3'($urandom));
            sp = (it % 8 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            run_irq(8'($urandom), 3'($urandom), $urandom, sp, 8'($urandom), 2'($urandom),
                    int'($urandom_range(0, 2)), 1, 0);
        end
        mem_rand = 0; stray_en = 0;
    endtask

    initial begin
        test_reset();
        test_mode2();
        test_mode0();
        test_wait_states();
        test_boundary_hold();
        test_reset_mid();
        test_mask_done();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
